// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES S-box tables, FSM state type and shared constants
//
// Purpose : shared definitions for the iterative SubBytes block.
// Contents: NUM_BYTES, state_t (IDLE/BUSY/DONE), SBOX and INV_SBOX tables.
package aes_pkg;

  localparam int NUM_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_lane.sv
// rtl/aes_sbox_lane.sv - single-byte AES S-box lookup lane
//
// Purpose : one combinational byte substitution.
// Macro   : AES_SUBBYTES_FWD_EN - when defined, both tables are built and
//           i_inv selects; when undefined only the inverse table exists.
// Ports   : i_byte - byte to substitute
//           i_inv  - 1 = inverse S-box, 0 = forward S-box
//           o_byte - substituted byte
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte
);

`ifdef AES_SUBBYTES_FWD_EN
  assign o_byte = i_inv ? INV_SBOX[i_byte] : SBOX[i_byte];
`else
  // Inverse-only build: mode input has no effect.
  logic w_unused_inv;
  assign w_unused_inv = i_inv;
  assign o_byte       = INV_SBOX[i_byte];
`endif

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// rtl/aes_sub_bytes_iter.sv - iterative AES SubBytes, NUM_SBOX bytes per cycle
//
// Purpose : substitutes a 128-bit state over 16/NUM_SBOX BUSY cycles.
// Macro   : AES_SUBBYTES_FWD_EN - defined: in_inv selects forward/inverse per
//           block; undefined: inverse only, in_inv ignored.
// Params  : NUM_SBOX - lanes per cycle (1, 2, 4, 8 or 16)
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready/in_inv/in_block - block input handshake
//           out_valid/out_ready/out_block     - registered result handshake
module aes_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  localparam int NUM_GRP = NUM_BYTES / NUM_SBOX;
  localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GRP - 1);

  generate
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
        NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
      $error("aes_sub_bytes_iter: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_t                  r_state;
  state_t                  w_state_next;
  logic [GRP_W-1:0]        r_grp;
  logic [127:0]            r_block;
  logic [127:0]            r_result;
  logic                    r_inv;
  logic [127:0]            w_result_next;
  logic [NUM_SBOX*8-1:0]   w_lane_in;
  logic [NUM_SBOX*8-1:0]   w_lane_out;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_inv_in;

`ifdef AES_SUBBYTES_FWD_EN
  assign w_inv_in = in_inv;
`else
  logic w_unused_in_inv;
  assign w_unused_in_inv = in_inv;
  assign w_inv_in        = 1'b1;
`endif

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_grp == GRP_LAST);
  assign out_block = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // in_ready is masked by rst so it stays low while reset is held even
  // though the state register already reads IDLE.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid) w_state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Select the current group of input bytes for the lanes.
  always_comb begin
    w_lane_in = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (r_grp == GRP_W'(g)) begin
        for (int l = 0; l < NUM_SBOX; l++) begin
          w_lane_in[l*8 +: 8] = r_block[(g*NUM_SBOX + l)*8 +: 8];
        end
      end
    end
  end

  // Write lane outputs back into the current group; other bytes hold.
  always_comb begin
    w_result_next = r_result;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (r_grp == GRP_W'(g)) begin
        for (int l = 0; l < NUM_SBOX; l++) begin
          w_result_next[(g*NUM_SBOX + l)*8 +: 8] = w_lane_out[l*8 +: 8];
        end
      end
    end
  end

  generate
    for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
      aes_sbox_lane u_lane (
        .i_byte (w_lane_in[l*8 +: 8]),
        .i_inv  (r_inv),
        .o_byte (w_lane_out[l*8 +: 8])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grp    <= '0;
      r_block  <= '0;
      r_inv    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_block <= in_block;
      r_inv   <= w_inv_in;
      r_grp   <= '0;
    end else if (r_state == ST_BUSY) begin
      r_result <= w_result_next;
      r_grp    <= w_last ? '0 : r_grp + 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// tb/tb_aes_sub_bytes_iter.sv - scoreboard bench for aes_sub_bytes_iter
module tb_aes_sub_bytes_iter;

  localparam int NUM_SBOX = 4;
  localparam int N        = 16 / NUM_SBOX;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic         in_inv    = 1'b0;
  logic [127:0] in_block  = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_block;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic         prev_valid = 1'b0;

  aes_sub_bytes_iter #(.NUM_SBOX(NUM_SBOX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box derived from GF(2^8) inversion plus the AES affine transform.
  task automatic build_tables();
    logic [7:0] b, s;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
        end
      end
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic eff_inv(input logic inv);
`ifdef AES_SUBBYTES_FWD_EN
    return inv;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [127:0] model(input logic [127:0] blk, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i*8 +: 8] = inv ? inv_tab[blk[i*8 +: 8]] : fwd_tab[blk[i*8 +: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send(input logic [127:0] blk, input logic inv, input logic [127:0] exp);
    bit got;
    @(posedge clk); #2;
    in_valid = 1'b1; in_block = blk; in_inv = inv;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        exp_q.push_back(exp);
        acc_q.push_back(cyc + 1);
      end
    end
    if (!got) check("in_ready_timeout", 128'(got), 128'(1));
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_block = rand_block();
    in_inv   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain", 128'(exp_q.size()), 128'(0));
    @(negedge clk);
    check("valid_one_cycle", 128'(out_valid), 128'(0));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() > 0) check("latency", 128'(cyc - acc_q[0]), 128'(N));
        else                  check("unexpected_valid", 128'(out_valid), 128'(0));
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check("data", out_block, exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      prev_valid = out_valid && !out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [127:0] blk, e;
    bit           seen;
    logic         inv;

    build_tables();

    repeat (3) @(negedge clk);
    check("reset_in_ready",  128'(in_ready),  128'(0));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_block", out_block,       128'(0));
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 128'(in_ready), 128'(1));

    send(128'h0, 1'b1, {16{8'h52}});
    wait_drain();

    for (int i = 0; i < 16; i++) blk[i*8 +: 8] = 8'(i);
    send(blk, 1'b1, model(blk, 1'b1));
    wait_drain();

`ifdef AES_SUBBYTES_FWD_EN
    send({16{8'h53}}, 1'b0, {16{8'hED}});
    wait_drain();
    send({16{8'hED}}, 1'b1, {16{8'h53}});
    wait_drain();
`else
    send({16{8'h63}}, 1'b0, 128'h0);
    wait_drain();
`endif

    for (int k = 0; k < 6; k++) begin
      blk = rand_block();
      inv = 1'($urandom_range(0, 1));
      send(blk, inv, model(blk, eff_inv(inv)));
    end
    wait_drain();

    @(posedge clk); #2 out_ready = 1'b0;
    blk = rand_block();
    e   = model(blk, 1'b1);
    send(blk, 1'b1, e);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    check("hold_reached", 128'(out_valid), 128'(1));
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #2;
      in_valid = 1'b1;
      in_block = rand_block();
      @(negedge clk);
      check("hold_valid",    128'(out_valid), 128'(1));
      check("hold_block",    out_block,       e);
      check("hold_in_ready", 128'(in_ready),  128'(0));
    end
    @(posedge clk); #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hold_idle", 128'(in_ready), 128'(1));
    check("post_hold_sb",   128'(exp_q.size()), 128'(0));

    blk = rand_block();
    send(blk, 1'b1, model(blk, 1'b1));
    #3 rst = 1'b1;
    #1;
    check("rst_in_ready",  128'(in_ready),  128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_block", out_block,       128'(0));
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", 128'(in_ready), 128'(1));
    seen = 1'b0;
    repeat (N + 3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_valid", 128'(seen), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_sub_bytes_iter.md
AES_SUB_BYTES_ITER -- requirements
Module: aes_sub_bytes_iter

Interface
REQ-001 SHALL have parameter NUM_SBOX, default 4: S-box lanes per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  block offered.
REQ-005 SHALL have port in_ready  output  1  block accepted when in_valid && in_ready at a clock edge.
REQ-006 SHALL have port in_inv  input  1  1 = inverse S-box, 0 = forward S-box; sampled with the block.
REQ-007 SHALL have port in_block  input  128  state; byte i = in_block[8i+7:8i].
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at a clock edge.
REQ-010 SHALL have port out_block  output  128  substituted state; byte i = S(in_block byte i).

Function
REQ-011 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-012 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-013 IDLE: on acceptance, SHALL latch in_block and in_inv, clear group counter grp, go to BUSY.
REQ-014 BUSY: each cycle SHALL substitute bytes grp*NUM_SBOX .. grp*NUM_SBOX+NUM_SBOX-1 into the result register, leaving other bytes unchanged.
REQ-015 grp SHALL increment each BUSY cycle; width $clog2(16/NUM_SBOX), minimum 1 bit.
REQ-016 The BUSY cycle with grp = 16/NUM_SBOX-1 SHALL transition to DONE; grp wraps to 0.
REQ-017 Latency SHALL be exactly N = 16/NUM_SBOX cycles: acceptance at edge k gives out_valid high after edge k+N.
REQ-018 DONE: out_block and out_valid SHALL hold stable until out_ready; on handshake, SHALL go to IDLE.
REQ-019 Minimum spacing between acceptances SHALL be N+2 cycles, with no overlap of blocks.
REQ-020 in_valid, in_inv and in_block SHALL be ignored outside IDLE; changes after acceptance SHALL NOT affect the result.
REQ-021 With NUM_SBOX = 16, SHALL spend one BUSY cycle (N = 1).
REQ-022 out_block SHALL be the result register; no combinational path from in_block to out_block.

Reset
REQ-023 While rst = 1 (asynchronous), state SHALL be IDLE, grp = 0, result = 0, latched mode = 0.
REQ-024 While rst = 1, outputs SHALL be in_ready = 0, out_valid = 0, out_block = 0.
REQ-025 in_ready SHALL rise the first cycle after rst deasserts.
REQ-026 Reset during BUSY or DONE SHALL discard the block; no out_valid SHALL follow for it.

Configuration
REQ-027 Macro AES_SUBBYTES_FWD_EN defined: forward and inverse tables SHALL both be present; in_inv selects per block.
REQ-028 Macro AES_SUBBYTES_FWD_EN undefined: only the inverse table SHALL be built; in_inv SHALL be ignored and always treated as 1.

Structure
REQ-029 Package aes_pkg SHALL hold the 256-entry SBOX and INV_SBOX byte tables, the FSM state enum, and localparam NUM_BYTES = 16.
REQ-030 Sub-module aes_sbox_lane SHALL provide one byte lookup (byte in, inv in, byte out) and be instantiated NUM_SBOX times via generate.
REQ-031 An illegal NUM_SBOX SHALL cause an elaboration-time error.

Verification
REQ-032 NUM_SBOX = 4, inv = 1, in_block = 128'h0, out_ready = 1: out_block = {16{8'h52}}, out_valid high 4 cycles after acceptance for 1 cycle.
REQ-033 FWD_EN defined, inv = 0, in_block = {16{8'h53}}: out_block = {16{8'hED}}; then inv = 1 on that output returns {16{8'h53}}.
REQ-034 NUM_SBOX = 1, in_block bytes 0x00..0x0F, inv = 1: result matches INV_SBOX per byte; latency 16; in_block scrambled during BUSY has no effect.
REQ-035 Hold out_ready = 0 for 10 cycles in DONE: out_valid and out_block stable; in_ready stays 0; a new in_valid is not accepted.
REQ-036 Assert rst mid-BUSY: outputs immediately 0; after release in_ready = 1 and no stale out_valid.
REQ-037 FWD_EN undefined, inv = 0, in_block = {16{8'h63}}: out_block = 128'h0 (inverse used).
